pal_timing_ctrl: RTL
====================

// Module: pal_timing_ctrl
// PURPOSE
//  Sequences the composite-video DAC path as a non-interlaced 312-line PAL raster.
//  Generates line/field timing with sync, blanking, equalising and broad pulses.
//  Fetches pixels from an upstream source over a fixed-latency request interface.
//  Drives the 8-bit DAC code; the board top ties dac_out to vga_r. Runs on clk50.
// PARAMETERS
//  H_TOTAL     3200  clocks per line (64 us @ 50 MHz)
//  H_SYNC      235   line sync low width (4.7 us); eq pulse = H_SYNC/2 = 117
//  H_ACT_START 525   first active clock of line
//  H_ACT_LEN   2600  active clocks per line (pixel_x 0..2599)
//  V_TOTAL     312   lines per field
//  V_ACT_START 23    first active line; V_ACT_LEN 287 active lines (pixel_y 0..286)
//  PIX_LAT     2     cycles from pix_req to valid pix_in (1..4)
//  SYNC_LVL    0     DAC code for sync tip; BLANK_LVL 77 blank/black code
// PORTS
//  clk50       in   1   system clock, 50 MHz
//  rst_n       in   1   asynchronous active-low reset
//  en          in   1   raster enable; low = hold idle
//  pix_in      in   8   pixel luma, valid PIX_LAT cycles after its pix_req
//  pix_req     out  1   pixel request strobe
//  pix_x       out  12  requested pixel column, valid with pix_req
//  pix_y       out  9   requested pixel row, valid with pix_req
//  dac_out     out  8   DAC code
//  csync_n     out  1   composite sync, low during any sync pulse
//  active      out  1   high while dac_out carries picture
//  frame_start out  1   1-cycle pulse when line 0 clock 0 reaches dac_out
// BEHAVIOUR
//  Reset: hcnt=0, vcnt=0, dac_out=BLANK_LVL, csync_n=1, pix_req=0, active=0,
//   frame_start=0, pix_x=0, pix_y=0. Reset is honoured mid-line; no partial state kept.
//  Counters: hcnt 0..H_TOTAL-1 wraps to 0, incrementing vcnt; vcnt wraps V_TOTAL-1 -> 0.
//  en low: counters held at 0, outputs at reset values. en rising: line 0 starts next cycle.
//  Line types by vcnt (half-line = H_TOTAL/2 = 1600 clocks):
//   0..2    BROAD: each half-line low H_TOTAL/2-H_SYNC (1365), then high
//   3..4    POSTEQ: each half-line low 117, then high
//   5..V_ACT_START-1  BLANK: low H_SYNC, then BLANK_LVL for rest of line
//   V_ACT_START..+V_ACT_LEN-1  ACTIVE: BLANK line with picture in active window
//   remaining lines to V_TOTAL-1 (310,311)  PREEQ: as POSTEQ
//  Low sync phase: dac_out=SYNC_LVL, csync_n=0. All other phases: BLANK_LVL,
//   except the active window.
//  Active window: ACTIVE line and H_ACT_START <= hcnt < H_ACT_START+H_ACT_LEN.
//   In the window, dac_out = max(pix_in, BLANK_LVL); clamp below black.
//  Output latency: dac_out/csync_n/active/frame_start are registered, 1 cycle after
//   the counters.
//  Fetch: pix_req issued PIX_LAT cycles ahead of the counter position.
//   - pix_req high for exactly H_ACT_LEN consecutive cycles per active line.
//   - pix_x increments 0..H_ACT_LEN-1; pix_y = vcnt-V_ACT_START.
//   - pix_in sampled PIX_LAT cycles after each pix_req.
//   - Requests for line 0 of a field may issue in the preceding line's blanking.
//   - No requests on non-active lines.
//  en falling mid-line: outstanding requests are dropped. pix_req deasserts the
//   next cycle, and pix_in is ignored.
//  Field rate: 312 x 3200 = 998400 clocks (50.08 Hz).
// TESTING
//  1 reset: rst_n=0 mid-line -> dac_out=77, csync_n=1, pix_req=0 within 1 cycle;
//    counters restart at 0.
//  2 blank line 10: csync_n low 235 clocks; dac_out 0 then 77; period 3200; no pix_req.
//  3 vsync: lines 0-2 show 6 low pulses of 1365; lines 3,4,310,311 show low pulses
//    of 117 every 1600 clocks.
//  4 active line 23: pix_req high 2600 cycles, pix_x 0..2599, pix_y=0.
//    Source returns pix_in=pix_x[7:0] after 2 cycles -> dac_out column k = max(k%256,77)
//    at counter hcnt 525+k.
//  5 clamp/lat: PIX_LAT=4, pix_in=10 -> dac_out=77 in window. Checker confirms
//    alignment at hcnt 525.
//  6 frame: frame_start pulses once every 998400 cycles. en low 1000 cycles ->
//    outputs idle; restart at line 0.

Source files
------------

// File: rtl/pal_timing_ctrl_if.sv
// Pixel fetch and DAC-side signal bundle for the PAL timing controller.
// master = timing controller, slave = pixel source / DAC consumer.
interface pal_timing_ctrl_if;
  logic        pix_req;
  logic [11:0] pix_x;
  logic [8:0]  pix_y;
  logic [7:0]  pix_in;
  logic [7:0]  dac_out;
  logic        csync_n;
  logic        active;
  logic        frame_start;

  modport master (
    input  pix_in,
    output pix_req, pix_x, pix_y, dac_out, csync_n, active, frame_start
  );

  modport slave (
    output pix_in,
    input  pix_req, pix_x, pix_y, dac_out, csync_n, active, frame_start
  );
endinterface

// File: rtl/pal_timing_ctrl.sv
// Non-interlaced PAL raster sequencer: broad/equalising/line sync, blanking and a
// fixed-latency pixel fetch that lands each pixel exactly on its DAC slot.
module pal_timing_ctrl #(
  parameter int         H_TOTAL     = 3200,
  parameter int         H_SYNC      = 235,
  parameter int         H_ACT_START = 525,
  parameter int         H_ACT_LEN   = 2600,
  parameter int         V_TOTAL     = 312,
  parameter int         V_ACT_START = 23,
  parameter int         V_ACT_LEN   = 287,
  parameter int         PIX_LAT     = 2,
  parameter logic [7:0] SYNC_LVL    = 8'd0,
  parameter logic [7:0] BLANK_LVL   = 8'd77
) (
  input  logic              clk50,
  input  logic              rst_n,
  input  logic              en,
  pal_timing_ctrl_if.master bus
);
  localparam int HW = 12;
  localparam int VW = 9;
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HALF     = HW'(H_TOTAL / 2);
  localparam logic [HW-1:0] BROAD_W  = HW'(H_TOTAL / 2 - H_SYNC);
  localparam logic [HW-1:0] EQ_W     = HW'(H_SYNC / 2);
  localparam logic [HW-1:0] SYNC_W   = HW'(H_SYNC);
  localparam logic [HW-1:0] HA0      = HW'(H_ACT_START);
  localparam logic [HW-1:0] HA1      = HW'(H_ACT_START + H_ACT_LEN);
  localparam logic [HW-1:0] LEAD     = HW'(PIX_LAT + 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VA0      = VW'(V_ACT_START);
  localparam logic [VW-1:0] VA1      = VW'(V_ACT_START + V_ACT_LEN);
  localparam logic [VW-1:0] V_BROAD  = VW'(3);
  localparam logic [VW-1:0] V_POSTEQ = VW'(5);

  // fh/fv run PIX_LAT+1 positions ahead of hcnt/vcnt; the registered request then
  // leads the counters by exactly PIX_LAT, so pix_in arrives as its slot is encoded.
  logic [HW-1:0] hcnt, hcnt_nxt, fh, fh_nxt, hh;
  logic [VW-1:0] vcnt, vcnt_nxt, fv, fv_nxt;
  logic          sync_low, in_win, req_win, frame0;
  logic [7:0]    dac_nxt;

  always_comb begin
    hcnt_nxt = '0;
    vcnt_nxt = '0;
    fh_nxt   = LEAD;
    fv_nxt   = '0;
    if (en) begin
      hcnt_nxt = (hcnt == H_LAST) ? '0 : hcnt + 1'b1;
      vcnt_nxt = vcnt;
      if (hcnt == H_LAST) vcnt_nxt = (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
      fh_nxt = (fh == H_LAST) ? '0 : fh + 1'b1;
      fv_nxt = fv;
      if (fh == H_LAST) fv_nxt = (fv == V_LAST) ? '0 : fv + 1'b1;
    end

    hh = (hcnt >= HALF) ? hcnt - HALF : hcnt;
    if (vcnt < V_BROAD)                       sync_low = hh < BROAD_W;
    else if (vcnt < V_POSTEQ || vcnt >= VA1)  sync_low = hh < EQ_W;
    else                                      sync_low = hcnt < SYNC_W;
    sync_low = sync_low && en;

    in_win  = en && vcnt >= VA0 && vcnt < VA1 && hcnt >= HA0 && hcnt < HA1;
    req_win = en && fv >= VA0 && fv < VA1 && fh >= HA0 && fh < HA1;
    frame0  = en && hcnt == '0 && vcnt == '0;

    dac_nxt = BLANK_LVL;
    if (sync_low)                                dac_nxt = SYNC_LVL;
    else if (in_win && bus.pix_in > BLANK_LVL)   dac_nxt = bus.pix_in;
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      hcnt            <= '0;
      vcnt            <= '0;
      fh              <= LEAD;
      fv              <= '0;
      bus.dac_out     <= BLANK_LVL;
      bus.csync_n     <= 1'b1;
      bus.active      <= 1'b0;
      bus.frame_start <= 1'b0;
      bus.pix_req     <= 1'b0;
      bus.pix_x       <= '0;
      bus.pix_y       <= '0;
    end else begin
      hcnt            <= hcnt_nxt;
      vcnt            <= vcnt_nxt;
      fh              <= fh_nxt;
      fv              <= fv_nxt;
      bus.dac_out     <= dac_nxt;
      bus.csync_n     <= !sync_low;
      bus.active      <= in_win;
      bus.frame_start <= frame0;
      bus.pix_req     <= req_win;
      bus.pix_x       <= req_win ? fh - HA0 : '0;
      bus.pix_y       <= req_win ? fv - VA0 : '0;
    end
  end
endmodule
